alu_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It sits beside the single-cycle EX-stage ALU in the pipeline CPU.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, plus single-cycle MTHI/MTLO.
- Raises busy so hazard control can stall MFHI/MFLO and further mul/div issue. Supports a flush from the pipeline.

---
 rtl/alu_muldiv.sv | 141 ++++++++++++++
 tb/tb_alu_muldiv.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: multiplies finish in one cycle via the * operator.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   mcand_reg, p_hi_reg, p_lo_reg, hi_reg, lo_reg;
    logic               is_div_reg, neg_lo_reg, neg_hi_reg, div_zero_reg;

    logic               issue_md, issue_mt;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   p_hi_next, p_lo_next;
    logic [2*WIDTH-1:0] raw_prod, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;

    assign issue_md = start && !flush && (state_reg == S_IDLE) && !op[2];
    assign issue_mt = start && !flush && (state_reg == S_IDLE) && (op[2:1] == 2'b10);

    // Signed ops run on magnitudes; signs are restored when the result is committed.
    assign a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    assign b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

    // p_hi/p_lo hold partial product (mul) or remainder/quotient (div).
    assign mul_sum   = {1'b0, p_hi_reg} + (p_lo_reg[0] ? {1'b0, mcand_reg} : '0);
    assign div_shift = {p_hi_reg, p_lo_reg[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_reg};
    assign div_ok    = !div_diff[WIDTH+1];

    always_comb begin
        p_hi_next = mul_sum[WIDTH:1];
        p_lo_next = {mul_sum[0], p_lo_reg[WIDTH-1:1]};
        if (is_div_reg) begin
            p_hi_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            p_lo_next = {p_lo_reg[WIDTH-2:0], div_ok};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    assign raw_prod = {{WIDTH{1'b0}}, mcand_reg} * {{WIDTH{1'b0}}, p_lo_reg};
`else
    assign raw_prod = {p_hi_reg, p_lo_reg};
`endif

    assign prod_fix = neg_lo_reg ? -raw_prod : raw_prod;
    assign q_fix    = div_zero_reg ? {WIDTH{1'b1}} : (neg_lo_reg ? -p_lo_reg : p_lo_reg);
    assign r_fix    = neg_hi_reg ? -p_hi_reg : p_hi_reg;
    assign fix_hi   = is_div_reg ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div_reg ? q_fix : prod_fix[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (issue_md) state_next = (FAST_MUL && !op[1]) ? S_FIN : S_RUN;
            S_RUN: begin
                if (flush)
                    state_next = S_IDLE;
                else if (cnt_reg == CNT_W'(1))
                    state_next = S_FIN;
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_FIN) && !flush;
    // Result is shown during FIN and committed on its closing edge, so a flush
    // in FIN leaves the architectural HI/LO untouched.
    assign hi   = done ? fix_hi : hi_reg;
    assign lo   = done ? fix_lo : lo_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            mcand_reg    <= '0;
            p_hi_reg     <= '0;
            p_lo_reg     <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            is_div_reg   <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            if (issue_md) begin
                cnt_reg      <= CNT_W'(WIDTH);
                mcand_reg    <= op[1] ? b_mag : a_mag;
                p_lo_reg     <= op[1] ? a_mag : b_mag;
                p_hi_reg     <= '0;
                is_div_reg   <= op[1];
                neg_lo_reg   <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi_reg   <= op[0] && a[WIDTH-1];
                div_zero_reg <= op[1] && (b == '0);
            end else if (state_reg == S_RUN) begin
                cnt_reg  <= cnt_reg - CNT_W'(1);
                p_hi_reg <= p_hi_next;
                p_lo_reg <= p_lo_next;
            end
            if (issue_mt && !op[0])
                hi_reg <= a;
            else if (issue_mt)
                lo_reg <= a;
            if (done) begin
                hi_reg <= fix_hi;
                lo_reg <= fix_lo;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv: MT ops, mul/div results and
// latency, divide-by-zero, MIN/-1, flush, busy issue and mid-run reset.
module tb_alu_muldiv;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;
    localparam int INJ     = (MUL_LAT >= 5) ? 5 : 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one mul/div op and check latency, result and return to idle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input int lat);
        int cyc;
        start = 1'b1; op = o; a = xa; b = xb;
        tick();
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h done_cycle=%0d", tag, o, xa, xb, hi, lo, cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        tick();
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_hold_hi"}, hi, eh);
        check({tag, "_hold_lo"}, lo, el);
    endtask

    initial begin
        int n_done;
        int first_done;
        logic [W-1:0] hi_at, lo_at;

        // Reset, with start/flush also asserted.
        start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hFFFF_FFFF;
        tick();
        tick();
        rst = 1'b0; start = 1'b0; flush = 1'b0;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        $display("reset -> hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);

        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        tick();
        start = 1'b0;
        $display("MTHI a=%h -> hi=%h lo=%h busy=%b", 32'h1234_5678, hi, lo, busy);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'd0);
        check("mthi_busy_done", {30'd0, busy, done}, 32'd0);

        start = 1'b1; op = 3'd5; a = 32'hCAFE_F00D;
        tick();
        start = 1'b0;
        $display("MTLO a=%h -> hi=%h lo=%h", 32'hCAFE_F00D, hi, lo);
        check("mtlo_lo", lo, 32'hCAFE_F00D);
        check("mtlo_hi", hi, 32'h1234_5678);

        start = 1'b1; op = 3'd6; a = 32'h1111_1111; b = 32'h2;
        tick();
        start = 1'b0;
        $display("reserved op=6 -> hi=%h lo=%h busy=%b", hi, lo, busy);
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_hi", hi, 32'h1234_5678);
        check("rsvd_lo", lo, 32'hCAFE_F00D);

        start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; flush = 1'b0;
        $display("MTHI with flush -> hi=%h", hi);
        check("idle_flush_hi", hi, 32'h1234_5678);
        check("idle_flush_busy", 32'(busy), 32'd0);

        run_op("multu", 3'd0, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT);
        run_op("divu", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
        run_op("div_by0", 3'd3, 32'h55, 32'd0, 32'h55, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_by0", 3'd2, 32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF, DIV_LAT);
        run_op("div_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);

        // Flush a DIVU in cycle 10: no done, HI/LO keep the MIN/-1 result.
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 50; c++) begin
            if (done) n_done++;
            if (c == 10) flush = 1'b1;
            tick();
            flush = 1'b0;
            if (c == 10) begin
                check("flush_busy", 32'(busy), 32'd0);
                check("flush_hi", hi, 32'd0);
                check("flush_lo", lo, 32'h8000_0000);
            end
        end
        $display("flushed DIVU -> hi=%h lo=%h done_pulses=%0d", hi, lo, n_done);
        check("flush_no_done", 32'(n_done), 32'd0);

        // Second start while busy must be ignored.
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0;
        n_done = 0; first_done = 0; hi_at = '0; lo_at = '0;
        for (int c = 1; c <= 80; c++) begin
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = c; hi_at = hi; lo_at = lo;
                end
            end
            if (c == INJ) begin
                start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
            end
            tick();
            start = 1'b0;
        end
        $display("MULTU 5*6 with start at cycle %0d -> hi=%h lo=%h done_cycle=%0d pulses=%0d",
                 INJ, hi_at, lo_at, first_done, n_done);
        check("busy_start_pulses", 32'(n_done), 32'd1);
        check("busy_start_lat", 32'(first_done), 32'(MUL_LAT));
        check("busy_start_hi", hi_at, 32'd0);
        check("busy_start_lo", lo_at, 32'd30);
        check("busy_start_final_lo", lo, 32'd30);

        // Reset mid-RUN with start and flush also high.
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 50; c++) begin
            if (done) n_done++;
            if (c == 15) begin
                rst = 1'b1; start = 1'b1; flush = 1'b1; op = 3'd3;
            end
            tick();
            rst = 1'b0; start = 1'b0; flush = 1'b0;
            if (c == 15) begin
                check("midrst_busy", 32'(busy), 32'd0);
                check("midrst_hi", hi, 32'd0);
                check("midrst_lo", lo, 32'd0);
            end
        end
        $display("reset mid-DIVU -> hi=%h lo=%h done_pulses=%0d", hi, lo, n_done);
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_final_lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
